// File: rtl/demo_diagnostic_nios2_ocimem_pkg.sv
// Shared types and jdo field map for the OCI debug-memory sequencer.
// Also decodes which JTAG operation a pulse requests.
package demo_diagnostic_nios2_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_LOAD,
        ST_J_WR,
        ST_J_RD,
        ST_J_CAP,
        ST_C_WR,
        ST_C_RD,
        ST_C_CAP
    } ocimem_state_e;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_LOAD_RD,
        OP_WR,
        OP_RD
    } jtag_op_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_MSB  = 33;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_RD_FLAG   = 34;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    // Highest-priority pulse wins: ocimem_b, then ocimem_a, then no_action.
    function automatic jtag_op_e jtag_decode(input logic take_b, input logic take_a,
                                             input logic rd_flag);
        if (take_b)
            return OP_WR;
        else if (take_a)
            return rd_flag ? OP_LOAD_RD : OP_LOAD;
        else
            return OP_RD;
    endfunction

endpackage

// File: rtl/demo_diagnostic_nios2_ocimem_rr_arb.sv
// Two-requester round-robin arbiter between the JTAG side and the CPU side.
// On contention the side that did not win the previous grant is chosen.
module demo_diagnostic_nios2_ocimem_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req_jtag,
    input  logic req_cpu,
    input  logic accept,
    output logic grant_jtag,
    output logic grant_cpu
);

    // Resets to "CPU granted last" so the JTAG side wins the first tie.
    logic last_grant_jtag_reg;

    always_comb begin
        grant_jtag = req_jtag;
        grant_cpu  = req_cpu;
        if (req_jtag && req_cpu) begin
            grant_jtag = ~last_grant_jtag_reg;
            grant_cpu  = last_grant_jtag_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant_jtag_reg <= 1'b0;
        else if (accept && (grant_jtag || grant_cpu))
            last_grant_jtag_reg <= grant_jtag;
    end

endmodule

// File: rtl/demo_diagnostic_nios2_cpu_ocimem_sequencer.sv
// Turns JTAG ocimem pulses into OCI RAM accesses with an auto-incrementing
// monitor address, sharing the single-port RAM with the CPU debug slave.
module demo_diagnostic_nios2_cpu_ocimem_sequencer
    import demo_diagnostic_nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] mon_addr,
    output logic [DATA_W-1:0] mon_dreg,
    output logic              mon_ready,
    output logic              jtag_overrun
);

    ocimem_state_e     state_reg;
    jtag_op_e          jtag_op_reg;
    logic              pending_reg;
    logic [ADDR_W-1:0] jtag_addr_reg;
    logic [DATA_W-1:0] jtag_data_reg;
    logic [ADDR_W-1:0] mon_addr_reg;
    logic [DATA_W-1:0] mon_dreg_reg;
    logic              overrun_reg;

    logic pulse_any, pulse_multi, jtag_in_flight, jtag_busy, cpu_req, in_c_state;
    logic grant_jtag, grant_cpu;
    logic unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

    assign pulse_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign pulse_multi = (take_action_ocimem_a & take_action_ocimem_b)
                       | (take_action_ocimem_a & take_no_action_ocimem_a)
                       | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign jtag_in_flight = (state_reg == ST_J_LOAD) || (state_reg == ST_J_WR)
                         || (state_reg == ST_J_RD)   || (state_reg == ST_J_CAP);
    assign jtag_busy  = pending_reg | jtag_in_flight;
    assign cpu_req    = cpu_read | cpu_write;
    assign in_c_state = (state_reg == ST_C_WR) || (state_reg == ST_C_RD)
                     || (state_reg == ST_C_CAP);

    demo_diagnostic_nios2_ocimem_rr_arb u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_jtag   (pending_reg),
        .req_cpu    (cpu_req),
        .accept     (state_reg == ST_IDLE),
        .grant_jtag (grant_jtag),
        .grant_cpu  (grant_cpu)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            jtag_op_reg   <= OP_LOAD;
            pending_reg   <= 1'b0;
            jtag_addr_reg <= '0;
            jtag_data_reg <= '0;
            mon_addr_reg  <= '0;
            mon_dreg_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            // Capture never coincides with a grant: a grant needs pending set.
            if (pulse_any) begin
                if (jtag_busy || pulse_multi)
                    overrun_reg <= 1'b1;
                if (!jtag_busy) begin
                    pending_reg   <= 1'b1;
                    jtag_op_reg   <= jtag_decode(take_action_ocimem_b, take_action_ocimem_a,
                                                 jdo[JDO_RD_FLAG]);
                    jtag_addr_reg <= ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
                    jtag_data_reg <= DATA_W'(jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]);
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_jtag) begin
                        pending_reg <= 1'b0;
                        case (jtag_op_reg)
                            OP_WR:   state_reg <= ST_J_WR;
                            OP_RD:   state_reg <= ST_J_RD;
                            default: state_reg <= ST_J_LOAD;
                        endcase
                    end else if (grant_cpu) begin
                        state_reg <= cpu_write ? ST_C_WR : ST_C_RD;
                    end
                end
                ST_J_LOAD: begin
                    mon_addr_reg <= jtag_addr_reg;
                    state_reg    <= (jtag_op_reg == OP_LOAD_RD) ? ST_J_RD : ST_IDLE;
                end
                ST_J_WR: begin
                    mon_addr_reg <= mon_addr_reg + ADDR_W'(1);
                    state_reg    <= ST_IDLE;
                end
                ST_J_RD:  state_reg <= ST_J_CAP;
                ST_J_CAP: begin
                    mon_dreg_reg <= ram_rdata;
                    mon_addr_reg <= mon_addr_reg + ADDR_W'(1);
                    state_reg    <= ST_IDLE;
                end
                ST_C_RD:  state_reg <= ST_C_CAP;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr        = in_c_state ? cpu_address : mon_addr_reg;
    assign ram_wdata       = in_c_state ? cpu_writedata : jtag_data_reg;
    assign ram_wren        = (state_reg == ST_J_WR) || (state_reg == ST_C_WR);
    assign cpu_waitrequest = cpu_req && !((state_reg == ST_C_WR) || (state_reg == ST_C_CAP));
    assign cpu_readdata    = ram_rdata;
    assign mon_addr        = mon_addr_reg;
    assign mon_dreg        = mon_dreg_reg;
    assign mon_ready       = ~pending_reg && (state_reg == ST_IDLE);
    assign jtag_overrun    = overrun_reg;

endmodule

// File: tb/tb_demo_diagnostic_nios2_cpu_ocimem_sequencer.sv
// Directed bench: JTAG op vector table plus hand-timed CPU, contention,
// overrun and mid-access reset sequences against a behavioural RAM.
module tb_demo_diagnostic_nios2_cpu_ocimem_sequencer;

    localparam int K_LOAD = 0, K_LOADRD = 1, K_WR = 2, K_RD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [7:0]  mon_addr;
    logic [31:0] mon_dreg;
    logic        mon_ready;
    logic        jtag_overrun;

    logic [31:0] mem [256];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demo_diagnostic_nios2_cpu_ocimem_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_readdata            (cpu_readdata),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .mon_addr                (mon_addr),
        .mon_dreg                (mon_dreg),
        .mon_ready               (mon_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_addr;
        logic [31:0] exp_dreg;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int kind, input logic [7:0] addr, input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        case (kind)
            K_LOAD:   j[33:26] = addr;
            K_LOADRD: begin j[33:26] = addr; j[34] = 1'b1; end
            K_WR:     j[34:3] = data;
            default:  ;
        endcase
        jdo = j;
        take_action_ocimem_a    = (kind == K_LOAD) || (kind == K_LOADRD);
        take_action_ocimem_b    = (kind == K_WR);
        take_no_action_ocimem_a = (kind == K_RD);
    endtask

    task automatic clear_pulse();
        jdo = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!mon_ready && n < 12) begin
            tick();
            n++;
        end
        check(name, {31'd0, mon_ready}, 32'd1);
    endtask

    task automatic run_op(input int kind, input logic [7:0] addr, input logic [31:0] data);
        tick();
        start_pulse(kind, addr, data);
        tick();
        clear_pulse();
        wait_ready("op_ready_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        vecs[0] = '{K_LOAD,   8'h10, 32'h0,  8'h10, 32'h0};
        vecs[1] = '{K_WR,     8'h00, 32'hA,  8'h11, 32'h0};
        vecs[2] = '{K_WR,     8'h00, 32'hB,  8'h12, 32'h0};
        vecs[3] = '{K_WR,     8'h00, 32'hC,  8'h13, 32'h0};
        vecs[4] = '{K_LOADRD, 8'h10, 32'h0,  8'h11, 32'hA};
        vecs[5] = '{K_RD,     8'h00, 32'h0,  8'h12, 32'hB};
        vecs[6] = '{K_LOAD,   8'hFF, 32'h0,  8'hFF, 32'hB};
        vecs[7] = '{K_WR,     8'h00, 32'h55, 8'h00, 32'hB};
        vecs[8] = '{K_LOADRD, 8'hFF, 32'h0,  8'h00, 32'h55};
        vecs[9] = '{K_RD,     8'h00, 32'h0,  8'h01, 32'h0};

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_mon_ready", {31'd0, mon_ready}, 32'd1);
        check("rst_mon_addr", {24'd0, mon_addr}, 32'h0);
        check("rst_mon_dreg", mon_dreg, 32'h0);
        check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
        check("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);

        // JTAG operation table
        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].kind, vecs[v].addr, vecs[v].data);
            $display("vec %0d kind=%0d mon_addr=%h mon_dreg=%h", v, vecs[v].kind, mon_addr, mon_dreg);
            check($sformatf("vec%0d_mon_addr", v), {24'd0, mon_addr}, {24'd0, vecs[v].exp_addr});
            check($sformatf("vec%0d_mon_dreg", v), mon_dreg, vecs[v].exp_dreg);
        end
        check("ram_10", mem[8'h10], 32'hA);
        check("ram_11", mem[8'h11], 32'hB);
        check("ram_12", mem[8'h12], 32'hC);
        check("ram_ff", mem[8'hFF], 32'h55);

        // CPU read of 0x10, data valid two cycles after the request
        tick();
        cpu_read = 1'b1; cpu_address = 8'h10;
        #1;
        check("crd_m0_wait", {31'd0, cpu_waitrequest}, 32'd1);
        tick();
        check("crd_m1_wait", {31'd0, cpu_waitrequest}, 32'd1);
        tick();
        check("crd_m2_wait", {31'd0, cpu_waitrequest}, 32'd0);
        check("crd_m2_data", cpu_readdata, 32'hA);
        $display("cpu read addr=10 data=%h", cpu_readdata);
        tick();
        cpu_read = 1'b0;

        // Contention: JTAG write pending while CPU write to 0x20 is held
        tick();
        start_pulse(K_WR, 8'h00, 32'h77);
        tick();
        clear_pulse();
        cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'h1234;
        #1;
        check("cont_n1_wait", {31'd0, cpu_waitrequest}, 32'd1);
        check("cont_n1_ready", {31'd0, mon_ready}, 32'd0);
        tick();
        check("cont_n2_wren", {31'd0, ram_wren}, 32'd1);
        check("cont_n2_addr", {24'd0, ram_addr}, 32'h01);
        check("cont_n2_wdata", ram_wdata, 32'h77);
        check("cont_n2_wait", {31'd0, cpu_waitrequest}, 32'd1);
        tick();
        check("cont_n3_wren", {31'd0, ram_wren}, 32'd0);
        check("cont_n3_wait", {31'd0, cpu_waitrequest}, 32'd1);
        check("cont_n3_mon_addr", {24'd0, mon_addr}, 32'h02);
        check("cont_n3_ready", {31'd0, mon_ready}, 32'd1);
        tick();
        check("cont_n4_wren", {31'd0, ram_wren}, 32'd1);
        check("cont_n4_addr", {24'd0, ram_addr}, 32'h20);
        check("cont_n4_wdata", ram_wdata, 32'h1234);
        check("cont_n4_wait", {31'd0, cpu_waitrequest}, 32'd0);
        tick();
        cpu_write = 1'b0;
        #1;
        check("cont_n5_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        check("cont_ram_01", mem[8'h01], 32'h77);
        check("cont_ram_20", mem[8'h20], 32'h1234);
        $display("contention jtag[01]=%h cpu[20]=%h", mem[8'h01], mem[8'h20]);

        // Overrun: second write pulse one cycle after the first is dropped
        check("ovr_before", {31'd0, jtag_overrun}, 32'd0);
        tick();
        start_pulse(K_WR, 8'h00, 32'h99);
        tick();
        start_pulse(K_WR, 8'h00, 32'h66);
        tick();
        clear_pulse();
        wait_ready("ovr_ready_timeout");
        repeat (3) tick();
        check("ovr_flag", {31'd0, jtag_overrun}, 32'd1);
        check("ovr_mon_addr", {24'd0, mon_addr}, 32'h03);
        check("ovr_ram_02", mem[8'h02], 32'h99);
        check("ovr_ram_03", mem[8'h03], 32'h0);
        $display("overrun flag=%0d ram[02]=%h", jtag_overrun, mem[8'h02]);

        // Exact read timing: mon_dreg updates at N+4
        run_op(K_LOAD, 8'h10, 32'h0);
        tick();
        start_pulse(K_RD, 8'h00, 32'h0);
        tick();
        clear_pulse();
        #1;
        check("rd_n1_ready", {31'd0, mon_ready}, 32'd0);
        tick();
        tick();
        check("rd_n3_dreg", mon_dreg, 32'h0);
        tick();
        check("rd_n4_dreg", mon_dreg, 32'hA);
        check("rd_n4_addr", {24'd0, mon_addr}, 32'h11);
        check("rd_n4_ready", {31'd0, mon_ready}, 32'd1);
        $display("timed read mon_dreg=%h mon_addr=%h", mon_dreg, mon_addr);

        // Reset asserted during J_RD aborts the read
        tick();
        start_pulse(K_RD, 8'h00, 32'h0);
        tick();
        clear_pulse();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, mon_ready}, 32'd1);
        check("mid_rst_addr", {24'd0, mon_addr}, 32'h0);
        check("mid_rst_dreg", mon_dreg, 32'h0);
        check("mid_rst_wren", {31'd0, ram_wren}, 32'd0);
        check("mid_rst_overrun", {31'd0, jtag_overrun}, 32'd0);
        tick();
        check("mid_rst_dreg_after", mon_dreg, 32'h0);
        check("mid_rst_ready_after", {31'd0, mon_ready}, 32'd1);
        $display("mid-read reset mon_addr=%h mon_dreg=%h", mon_addr, mon_dreg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
